// File: rtl/axi_lite_sram.sv
// AXI-lite style memory with independent read/write channel FSMs and per-channel access latency.
// Define SRAM_RAND_DELAY_EN to add 0..7 pseudo-random extra cycles to each access.
module axi_lite_sram #(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1,
   parameter int WR_LAT = 1,
   parameter int MEM_AW = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arvalid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [1:0]        arsize,
   input  logic              load_unsign,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic              awvalid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [1:0]        awsize,
   output logic              awready,
   input  logic              wvalid,
   input  logic [31:0]       wdata,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready
);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   r_state_t          r_state;
   w_state_t          w_state;
   logic [4:0]        r_cnt, w_cnt, rd_lat, wr_lat, extra;
   logic [31:0]       r_addr, w_addr, w_dat;
   logic [1:0]        r_size, w_size;
   logic              r_uns, aw_cap, w_cap;
   logic [7:0]        mem [0:(1<<MEM_AW)-1];

   logic              ar_hs, aw_hs, w_hs, wr_start, rd_now, wr_now, wr_ok, wr_fire;
   logic [31:0]       rd_a, wr_a, wr_d;
   logic [1:0]        rd_sz, wr_sz;
   logic              rd_uns;
   logic [2:0]        wr_len;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign extra = {2'b00, lfsr[2:0]};
`else
   assign extra = 5'd0;
`endif

   // Accesses past the backing store answer SLVERR like misaligned ones.
   function automatic logic legal(input logic [31:0] a, input logic [1:0] sz);
      logic ok;
      ok = (a[31:MEM_AW] == '0);
      case (sz)
         2'd0:    legal = ok;
         2'd1:    legal = ok && !a[0];
         2'd2:    legal = ok && (a[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   endfunction

   assign arready  = (r_state == R_IDLE) && !reset;
   assign rvalid   = (r_state == R_RESP) && !reset;
   assign awready  = (w_state == W_IDLE) && !aw_cap && !reset;
   assign wready   = (w_state == W_IDLE) && !w_cap && !reset;
   assign bvalid   = (w_state == W_RESP) && !reset;

   assign ar_hs    = arvalid && arready;
   assign aw_hs    = awvalid && awready;
   assign w_hs     = wvalid && wready;
   assign rd_lat   = 5'(RD_LAT) + extra;
   assign wr_lat   = 5'(WR_LAT) + extra;

   // A zero-cycle latency completes straight from IDLE, so the live request is used there.
   assign rd_a     = (r_state == R_IDLE) ? 32'(araddr) : r_addr;
   assign rd_sz    = (r_state == R_IDLE) ? arsize : r_size;
   assign rd_uns   = (r_state == R_IDLE) ? load_unsign : r_uns;
   assign rd_now   = !reset && ((ar_hs && rd_lat == 5'd0) || (r_state == R_WAIT && r_cnt == 5'd0));

   assign wr_a     = aw_cap ? w_addr : 32'(awaddr);
   assign wr_sz    = aw_cap ? w_size : awsize;
   assign wr_d     = w_cap ? w_dat : wdata;
   assign wr_len   = 3'd1 << wr_sz;
   assign wr_start = (w_state == W_IDLE) && (aw_cap || aw_hs) && (w_cap || w_hs);
   assign wr_now   = !reset && ((wr_start && wr_lat == 5'd0) || (w_state == W_WAIT && w_cnt == 5'd0));
   assign wr_ok    = legal(wr_a, wr_sz);
   assign wr_fire  = wr_now && wr_ok;

   // A write completing on the same edge is forwarded so the read observes the new bytes.
   function automatic logic [7:0] rd_byte(input logic [MEM_AW-1:0] ba);
      logic [MEM_AW-1:0] off;
      logic [31:0]       sh;
      off = ba - wr_a[MEM_AW-1:0];
      sh  = wr_d >> {off[1:0], 3'b000};
      if (wr_fire && off < MEM_AW'(wr_len)) rd_byte = sh[7:0];
      else                                  rd_byte = mem[ba];
   endfunction

   function automatic logic [31:0] mem_read(input logic [MEM_AW-1:0] ia, input logic [1:0] sz,
                                            input logic uns);
      logic [7:0] b0, b1, b2, b3;
      b0 = rd_byte(ia);
      b1 = rd_byte(ia + MEM_AW'(1));
      b2 = rd_byte(ia + MEM_AW'(2));
      b3 = rd_byte(ia + MEM_AW'(3));
      case (sz)
         2'd0:    mem_read = uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
         2'd1:    mem_read = uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: mem_read = {b3, b2, b1, b0};
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int j = 0; j < 4; j++)
            if (3'(j) < wr_len) mem[wr_a[MEM_AW-1:0] + MEM_AW'(j)] <= wr_d[8*j +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= R_IDLE;
         r_cnt   <= 5'd0;
         r_addr  <= 32'd0;
         r_size  <= 2'd0;
         r_uns   <= 1'b0;
         rdata   <= 32'd0;
         rresp   <= 2'b00;
      end else begin
         case (r_state)
            R_IDLE: if (ar_hs) begin
               r_addr <= 32'(araddr);
               r_size <= arsize;
               r_uns  <= load_unsign;
               if (rd_lat == 5'd0) r_state <= R_RESP;
               else begin
                  r_cnt   <= rd_lat - 5'd1;
                  r_state <= R_WAIT;
               end
            end
            R_WAIT: if (r_cnt == 5'd0) r_state <= R_RESP;
                    else               r_cnt   <= r_cnt - 5'd1;
            R_RESP: if (rready) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
         if (rd_now) begin
            rdata <= legal(rd_a, rd_sz) ? mem_read(rd_a[MEM_AW-1:0], rd_sz, rd_uns) : 32'd0;
            rresp <= legal(rd_a, rd_sz) ? 2'b00 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_cnt   <= 5'd0;
         aw_cap  <= 1'b0;
         w_cap   <= 1'b0;
         w_addr  <= 32'd0;
         w_size  <= 2'd0;
         w_dat   <= 32'd0;
         bresp   <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_cap <= 1'b1;
            w_addr <= 32'(awaddr);
            w_size <= awsize;
         end
         if (w_hs) begin
            w_cap <= 1'b1;
            w_dat <= wdata;
         end
         case (w_state)
            W_IDLE: if (wr_start) begin
               if (wr_lat == 5'd0) w_state <= W_RESP;
               else begin
                  w_cnt   <= wr_lat - 5'd1;
                  w_state <= W_WAIT;
               end
            end
            W_WAIT: if (w_cnt == 5'd0) w_state <= W_RESP;
                    else               w_cnt   <= w_cnt - 5'd1;
            W_RESP: if (bready) begin
               aw_cap  <= 1'b0;
               w_cap   <= 1'b0;
               w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
         if (wr_now) bresp <= wr_ok ? 2'b00 : 2'b10;
      end
   end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed vector table, corner sequences, randomized traffic.
module tb_axi_lite_sram;
   localparam int ADDR_W = 32;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              arvalid = 1'b0, load_unsign = 1'b0, rready = 1'b0;
   logic [ADDR_W-1:0] araddr = '0, awaddr = '0;
   logic [1:0]        arsize = 2'd0, awsize = 2'd0;
   logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [31:0]       wdata = 32'd0;
   logic              arready, rvalid, awready, wready, bvalid;
   logic [31:0]       rdata;
   logic [1:0]        rresp, bresp;

   always #5 clk = ~clk;

   axi_lite_sram #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
      .clk(clk), .reset(reset),
      .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .load_unsign(load_unsign),
      .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   logic [7:0] ref_mem [0:4095];

   // Number of clock edges since reset released, i.e. how far the delay LFSR has advanced.
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int extra_at(input int n);
      if (n < 0) return 0;
`ifdef SRAM_RAND_DELAY_EN
      begin
         logic [7:0] l;
         l = 8'hA5;
         for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
         return int'(l[2:0]);
      end
`else
      return 0;
`endif
   endfunction

   function automatic bit ref_legal(input logic [31:0] a, input logic [1:0] sz);
      int len;
      len = 1 << sz;
      return (sz != 2'd3) && ((a % len) == 0);
   endfunction

   function automatic void ref_read(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                                    output logic [31:0] d, output logic [1:0] r);
      int len;
      len = 1 << sz;
      d = 32'd0;
      r = 2'b10;
      if (ref_legal(a, sz)) begin
         for (int i = 0; i < len; i++) d = d | (32'(ref_mem[a + i]) << (8 * i));
         if (!uns && len < 4 && d[8*len-1]) d = d | ~((32'd1 << (8 * len)) - 32'd1);
         r = 2'b00;
      end
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      if (ref_legal(a, sz))
         for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = d[8*i +: 8];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   task automatic rd_txn(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         output logic [31:0] d, output logic [1:0] r, output int k, output int hc);
      araddr = a; arsize = sz; load_unsign = uns; arvalid = 1'b1;
      hc = -1;
      for (int i = 0; i < 50 && hc < 0; i++) begin
         #1;
         if (arready) hc = cyc;
         @(negedge clk);
      end
      arvalid = 1'b0;
      if (hc < 0) begin
         total_cnt++;
         $display("FAIL ar_handshake: arready never seen within 50 cycles");
      end
      k = 1;
      while (!rvalid && k < 60) begin @(negedge clk); k++; end
      d = rdata; r = rresp;
      rready = 1'b1; @(negedge clk); rready = 1'b0;
   endtask

   // lead > 0: W handshakes that many cycles before AW; lead < 0: AW first.
   task automatic wr_txn(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d, input int lead,
                         output logic [1:0] r, output int k, output int hc);
      int a0, w0;
      bit ad, wd, ah, wh;
      a0 = (lead > 0) ? lead : 0;
      w0 = (lead < 0) ? -lead : 0;
      ad = 0; wd = 0; hc = -1;
      awaddr = a; awsize = sz; wdata = d;
      for (int c = 0; c < 60 && !(ad && wd); c++) begin
         awvalid = (c >= a0) && !ad;
         wvalid  = (c >= w0) && !wd;
         #1;
         ah = awvalid && awready;
         wh = wvalid && wready;
         if (ah || wh) hc = cyc;
         @(negedge clk);
         if (ah) ad = 1;
         if (wh) wd = 1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(ad && wd)) begin
         total_cnt++;
         $display("FAIL wr_handshake: aw_done=%0d w_done=%0d after 60 cycles", ad, wd);
      end
      k = 1;
      while (!bvalid && k < 60) begin @(negedge clk); k++; end
      r = bresp;
      bready = 1'b1; @(negedge clk); bready = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] data;
      int          lead;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
   } vec_t;

   vec_t vt [0:15];
   int   nv = 0;

   task automatic add(input bit wr, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                      input logic [31:0] d, input int lead, input logic [31:0] ed, input logic [1:0] er);
      vt[nv].wr = wr; vt[nv].addr = a; vt[nv].sz = sz; vt[nv].uns = uns;
      vt[nv].data = d; vt[nv].lead = lead; vt[nv].exp_d = ed; vt[nv].exp_r = er;
      nv++;
   endtask

   initial begin
      logic [31:0] d, ed, a;
      logic [1:0]  r, er, sz;
      logic        uns;
      int          k, hc, lead;
      bit          seen;

      add(1, 32'h100, 2'd2, 0, 32'hDEADBEEF, 0,  32'h0,        2'b00);
      add(1, 32'h104, 2'd2, 0, 32'h55667788, -1, 32'h0,        2'b00);
      add(0, 32'h100, 2'd2, 0, 32'h0,        0,  32'hDEADBEEF, 2'b00);
      add(0, 32'h101, 2'd0, 0, 32'h0,        0,  32'hFFFFFFBE, 2'b00);
      add(0, 32'h101, 2'd0, 1, 32'h0,        0,  32'h000000BE, 2'b00);
      add(1, 32'h202, 2'd1, 0, 32'h0000ABCD, 2,  32'h0,        2'b00);
      add(0, 32'h202, 2'd1, 1, 32'h0,        0,  32'h0000ABCD, 2'b00);
      add(0, 32'h102, 2'd2, 0, 32'h0,        0,  32'h00000000, 2'b10);
      add(0, 32'h100, 2'd3, 0, 32'h0,        0,  32'h00000000, 2'b10);
      add(1, 32'h106, 2'd2, 0, 32'h11223344, 0,  32'h0,        2'b10);
      add(0, 32'h104, 2'd2, 0, 32'h0,        0,  32'h55667788, 2'b00);
      add(0, 32'h102, 2'd1, 0, 32'h0,        0,  32'hFFFFDEAD, 2'b00);
      add(1, 32'h203, 2'd1, 0, 32'h00001234, 1,  32'h0,        2'b10);
      add(0, 32'h203, 2'd0, 1, 32'h0,        0,  32'h000000AB, 2'b00);

      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", {25'd0, arready, awready, wready, rvalid, bvalid, rresp == 2'b00, bresp == 2'b00},
          {25'd0, 5'b00000, 2'b11});
      chk("reset_rdata", rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", {29'd0, arready, awready, wready}, 32'd7);
      @(negedge clk);

      for (int i = 0; i < 'h300; i += 4) begin
         d = $urandom;
         wr_txn(i, 2'd2, d, 0, r, k, hc);
         ref_write(i, 2'd2, d);
      end

      for (int i = 0; i < nv; i++) begin
         if (vt[i].wr) begin
            wr_txn(vt[i].addr, vt[i].sz, vt[i].data, vt[i].lead, r, k, hc);
            chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_wlat", i), k, 1 + WR_LAT + extra_at(hc));
            ref_write(vt[i].addr, vt[i].sz, vt[i].data);
         end else begin
            rd_txn(vt[i].addr, vt[i].sz, vt[i].uns, d, r, k, hc);
            chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_d);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_rlat", i), k, 1 + RD_LAT + extra_at(hc));
         end
      end

      // Response held under back-pressure; no new address accepted meanwhile.
      ref_read(32'h100, 2'd2, 1'b0, ed, er);
      araddr = 32'h100; arsize = 2'd2; load_unsign = 1'b0; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < 60) begin @(negedge clk); k++; end
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_ctrl", i), {30'd0, rvalid, arready}, 32'd2);
         chk($sformatf("stall%0d_rdata", i), rdata, ed);
         @(negedge clk);
      end
      rready = 1'b1;
      #1;
      chk("stall_rready_cycle_arready", {31'd0, arready}, 32'd0);
      @(negedge clk);
      rready = 1'b0;
      #1;
      chk("stall_released", {30'd0, rvalid, arready}, 32'd1);
      @(negedge clk);

`ifndef SRAM_RAND_DELAY_EN
      // Read and write finish on the same edge; the read must return the freshly written word.
      araddr = 32'h0F0; arsize = 2'd2; load_unsign = 1'b0; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      awaddr = 32'h0F0; awsize = 2'd2; wdata = 32'h13579BDF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("same_edge_valids", {30'd0, rvalid, bvalid}, 32'd3);
      chk("same_edge_rdata", rdata, 32'h13579BDF);
      rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      ref_write(32'h0F0, 2'd2, 32'h13579BDF);
      @(negedge clk);
`endif

      // Reset while the write is still counting down: it must never land.
      awaddr = 32'h104; awsize = 2'd2; wdata = 32'hCAFEF00D; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 1) reset = 1'b0;
         #1;
         if (bvalid) seen = 1;
      end
      chk("reset_abandon_bvalid", {31'd0, seen}, 32'd0);
      rd_txn(32'h104, 2'd2, 1'b0, d, r, k, hc);
      chk("reset_abandon_mem", d, 32'h55667788);

      for (int n = 0; n < 150; n++) begin
         a    = $urandom_range(0, 'h2FF);
         sz   = 2'($urandom);
         uns  = 1'($urandom);
         lead = int'($urandom_range(0, 4)) - 2;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            wr_txn(a, sz, d, lead, r, k, hc);
            chk($sformatf("rnd%0d_bresp a=%h sz=%0d", n, a, sz), 32'(r),
                ref_legal(a, sz) ? 32'd0 : 32'd2);
            chk($sformatf("rnd%0d_wlat", n), k, 1 + WR_LAT + extra_at(hc));
            ref_write(a, sz, d);
         end else begin
            rd_txn(a, sz, uns, d, r, k, hc);
            ref_read(a, sz, uns, ed, er);
            chk($sformatf("rnd%0d_rdata a=%h sz=%0d u=%0d", n, a, sz, uns), d, ed);
            chk($sformatf("rnd%0d_rresp", n), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_rlat", n), k, 1 + RD_LAT + extra_at(hc));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

Parametrised AXI-lite-style simulation memory for the core's instruction/data ports. It replaces the single-cycle, always-ready memory model with independent read and write channel FSMs and a configurable access latency per channel. It adds SLVERR responses for misaligned or illegal-size accesses and optional pseudo-random extra delay. Storage is the simulator-side memory, reached through the DPI functions `mem_read(addr, len)` and `mem_write(addr, len, data)`.

## Interface
Parameters:
- ADDR_W, 32, address width; zero-extended to 32 bits before the DPI calls.
- RD_LAT, 1, extra read cycles, range 0..15.
- WR_LAT, 1, extra write cycles, range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- arvalid  in  1  read address valid.
- araddr  in  ADDR_W  read byte address.
- arsize  in  2  0=1B, 1=2B, 2=4B, 3=illegal.
- load_unsign  in  1  1 = zero-extend, 0 = sign-extend sub-word reads.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rvalid  out  1  read response valid.
- rready  in  1  read response ready.
- awvalid  in  1  write address valid.
- awaddr  in  ADDR_W  write byte address.
- awsize  in  2  encoded as arsize.
- awready  out  1  write address ready.
- wvalid  in  1  write data valid.
- wdata  in  32  write data; low bytes used.
- wready  out  1  write data ready.
- bresp  out  2  encoded as rresp.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

## Operation
- Read FSM states: R_IDLE → R_WAIT → R_RESP.
  - R_IDLE: arready=1. On arvalid, latch addr/size/sign and load the counter with RD_LAT+extra.
  - R_WAIT: decrement each cycle. At 0, perform the access and go to R_RESP.
  - R_RESP: rvalid=1 with rdata/rresp held stable. On rready, return to R_IDLE.
- Read access:
  - Legal and aligned: rdata = mem_read(addr, 1<<size), extended per the latched load_unsign; rresp=00.
  - Illegal size (3) or misaligned (addr mod len ≠ 0): no DPI call, rdata=0, rresp=10.
- Write FSM states: W_IDLE → W_WAIT → W_RESP.
  - W_IDLE: awready = !aw_captured, wready = !w_captured. AW and W may arrive in the same cycle or either order; each is latched on its own handshake.
  - Once both are captured: load the counter with WR_LAT+extra and go to W_WAIT.
  - W_WAIT: at 0, call mem_write(addr, len, wdata) if legal and aligned, else skip it and set bresp=10. Go to W_RESP.
  - W_RESP: bvalid=1. On bready, clear both captures and return to W_IDLE.
- Read and write channels are fully independent. At most one outstanding transaction per channel.
- Same-cycle read and write access completion: the write DPI call executes before the read DPI call, so the read sees the new data.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. All FSMs go to IDLE and captures clear.
- The ready outputs rise on the first cycle with reset low.
- Read latency: AR handshake in cycle T gives rvalid in cycle T+1+RD_LAT+extra.
- Write latency: last of AW/W handshakes in cycle T gives bvalid in cycle T+1+WR_LAT+extra.
- rvalid/bvalid stay high until their ready is sampled high. The response and the next address handshake cannot share a cycle, so arready=0 in the rready cycle.
- Reset asserted mid-transaction abandons it. A pending write never reaches memory if reset arrives before its counter expires.
- The counter is 5 bits wide (max 15+7=22).

## Configuration
- SRAM_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) seeds to 8'hA5 on reset and advances every cycle.
  - At each counter load, extra = lfsr[2:0]. Read and write sample the same LFSR value if they load in the same cycle.
- Undefined: extra=0; latencies are exactly RD_LAT/WR_LAT.

## Test plan
- RD_LAT=2, mem[0x100]=0xDEADBEEF, 4B read of 0x100 → rvalid exactly 3 cycles after the handshake, rdata=0xDEADBEEF, rresp=00.
- 1B read of 0x101 with byte 0xBE, load_unsign=0 → rdata=0xFFFFFFBE; with load_unsign=1 → rdata=0x000000BE.
- W handshake 2 cycles before AW, 2B write of 0xABCD to 0x202, WR_LAT=1 → bvalid 2 cycles after the AW handshake; a later 2B read of 0x202 returns 0x0000ABCD (unsigned).
- 4B read of 0x102 and arsize=3 read → rresp=10, rdata=0, no mem_read call. 4B write to 0x106 → bresp=10 and memory unchanged.
- rready held low for 5 cycles → rvalid and rdata stable throughout, arready=0. Reset asserted during W_WAIT → bvalid never asserts and memory is unchanged.
- With SRAM_RAND_DELAY_EN defined, RD_LAT=0, first read issued 3 cycles after reset → latency equals 1+lfsr[2:0] from the reference LFSR model, and the sequence is repeatable across runs.
